// File: rtl/blueintegral_mat_factor.sv
// Searches all 256 packed binary 2x2 pairs (A,B) for the first whose product
// equals the requested 2-bit-entry matrix C; start/done handshake.
module blueintegral_mat_factor #(
  parameter bit DESCENDING = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] c_in,
  output logic       busy,
  output logic       done,
  output logic       found,
  output logic [7:0] ab_out
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  localparam logic [7:0] FIRST_CAND = DESCENDING ? 8'hFF : 8'h00;
  localparam logic [7:0] LAST_CAND  = DESCENDING ? 8'h00 : 8'hFF;

  state_t     state_q, state_d;
  logic [7:0] cand_q, cand_d;
  logic [7:0] c_q, c_d;
  logic       found_q, found_d;
  logic [7:0] ab_q, ab_d;

  // Product of A=ab[7:4], B=ab[3:0] in the multiplier's packing.
  function automatic logic [7:0] mat_mul(input logic [7:0] ab);
    logic [1:0] p00, p01, p10, p11;
    p00 = {1'b0, ab[7] & ab[3]} + {1'b0, ab[6] & ab[1]};
    p01 = {1'b0, ab[7] & ab[2]} + {1'b0, ab[6] & ab[0]};
    p10 = {1'b0, ab[5] & ab[3]} + {1'b0, ab[4] & ab[1]};
    p11 = {1'b0, ab[5] & ab[2]} + {1'b0, ab[4] & ab[0]};
    return {p00, p01, p10, p11};
  endfunction

  // A field of 3 can never be produced, so such requests skip the search.
  function automatic logic c_invalid(input logic [7:0] c);
    return (c[7:6] == 2'b11) || (c[5:4] == 2'b11) ||
           (c[3:2] == 2'b11) || (c[1:0] == 2'b11);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cand_q  <= 8'h00;
      c_q     <= 8'h00;
      found_q <= 1'b0;
      ab_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      c_q     <= c_d;
      found_q <= found_d;
      ab_q    <= ab_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    c_d     = c_q;
    found_d = found_q;
    ab_d    = ab_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          c_d = c_in;
          if (c_invalid(c_in)) begin
            found_d = 1'b0;
            ab_d    = 8'h00;
            state_d = DONE;
          end else begin
            cand_d  = FIRST_CAND;
            state_d = SEARCH;
          end
        end
      end
      SEARCH: begin
        if (mat_mul(cand_q) == c_q) begin
          found_d = 1'b1;
          ab_d    = cand_q;
          state_d = DONE;
        end else if (cand_q == LAST_CAND) begin
          found_d = 1'b0;
          ab_d    = 8'h00;
          state_d = DONE;
        end else begin
          cand_d = DESCENDING ? cand_q - 8'd1 : cand_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q == SEARCH);
  assign done   = (state_q == DONE);
  assign found  = found_q;
  assign ab_out = ab_q;

endmodule

// File: tb/tb_blueintegral_mat_factor.sv
// Bench: ascending and descending instances share stimulus and are compared
// against a brute-force matrix-product model.
module tb_blueintegral_mat_factor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] c_in;
  logic [1:0] busy_v, done_v, found_v;
  logic [7:0] ab0, ab1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  blueintegral_mat_factor #(.DESCENDING(1'b0)) dut_asc (
    .clk(clk), .rst_n(rst_n), .start(start), .c_in(c_in),
    .busy(busy_v[0]), .done(done_v[0]), .found(found_v[0]), .ab_out(ab0));

  blueintegral_mat_factor #(.DESCENDING(1'b1)) dut_desc (
    .clk(clk), .rst_n(rst_n), .start(start), .c_in(c_in),
    .busy(busy_v[1]), .done(done_v[1]), .found(found_v[1]), .ab_out(ab1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Returns search position of the first solution, -1 if none, -2 if C invalid.
  function automatic int model_k(input logic [7:0] c, input bit desc, output logic [7:0] ab);
    int cm[4];
    int a[4];
    int b[4];
    int cand;
    ab = 8'h00;
    for (int f = 0; f < 4; f++) begin
      cm[f] = (int'(c) >> (6 - 2 * f)) & 3;
      if (cm[f] == 3) return -2;
    end
    for (int i = 0; i < 256; i++) begin
      cand = desc ? 255 - i : i;
      for (int n = 0; n < 4; n++) begin
        a[n] = (cand >> (7 - n)) & 1;
        b[n] = (cand >> (3 - n)) & 1;
      end
      if (a[0] * b[0] + a[1] * b[2] == cm[0] && a[0] * b[1] + a[1] * b[3] == cm[1] &&
          a[2] * b[0] + a[3] * b[2] == cm[2] && a[2] * b[1] + a[3] * b[3] == cm[3]) begin
        ab = cand[7:0];
        return i;
      end
    end
    return -1;
  endfunction

  // inject: 0 none, 1 stray start at cycle 50, 2 reset at cycle 50.
  task automatic run(input logic [7:0] c, input int inject);
    int lat[2];
    int bcnt[2];
    bit seen[2];
    int k;
    int exp_lat;
    logic [7:0] exp_ab;
    logic [7:0] got_ab;
    seen[0] = 1'b0; seen[1] = 1'b0;
    bcnt[0] = 0;    bcnt[1] = 0;
    lat[0] = -1;    lat[1] = -1;
    @(negedge clk);
    c_in  = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 300 && !(seen[0] && seen[1]); cyc++) begin
      for (int d = 0; d < 2; d++) begin
        if (!seen[d]) begin
          if (busy_v[d]) bcnt[d]++;
          if (done_v[d]) begin
            seen[d] = 1'b1;
            lat[d]  = cyc;
          end
        end
      end
      if (inject == 2 && cyc == 50) begin
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", {30'd0, busy_v}, 32'd0);
        check("rst_mid_done", {30'd0, done_v}, 32'd0);
        check("rst_mid_found", {30'd0, found_v}, 32'd0);
        check("rst_mid_ab", {16'd0, ab1, ab0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      start = (inject == 1 && cyc == 50);
      c_in  = (inject == 1 && cyc == 50) ? 8'h00 : c;
      @(negedge clk);
    end
    start = 1'b0;
    for (int d = 0; d < 2; d++) begin
      k = model_k(c, d[0], exp_ab);
      exp_lat = (k == -2) ? 0 : (k == -1) ? 256 : k + 1;
      got_ab = (d == 0) ? ab0 : ab1;
      check($sformatf("seen_%0d_%h", d, c), {31'd0, seen[d]}, 32'd1);
      check($sformatf("lat_%0d_%h", d, c), lat[d], exp_lat);
      check($sformatf("busy_%0d_%h", d, c), bcnt[d], exp_lat);
      check($sformatf("found_%0d_%h", d, c), {31'd0, found_v[d]}, {31'd0, k >= 0});
      check($sformatf("ab_%0d_%h", d, c), {24'd0, got_ab}, {24'd0, exp_ab});
    end
    @(negedge clk);
    check($sformatf("done_pulse_%h", c), {30'd0, done_v}, 32'd0);
    check($sformatf("hold_found_%h", c), {30'd0, found_v},
          {30'd0, model_k(c, 1'b1, exp_ab) >= 0, model_k(c, 1'b0, exp_ab) >= 0});
  endtask

  initial begin
    logic [7:0] rc;
    rst_n = 1'b0;
    start = 1'b0;
    c_in  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_busy", {30'd0, busy_v}, 32'd0);
    check("rst_done", {30'd0, done_v}, 32'd0);
    check("rst_found", {30'd0, found_v}, 32'd0);
    check("rst_ab", {16'd0, ab1, ab0}, 32'd0);
    rst_n = 1'b1;

    run(8'h00, 0);
    run(8'h41, 0);
    run(8'h80, 0);
    run(8'h82, 0);
    run(8'hFF, 0);
    run(8'h82, 1);
    run(8'h82, 2);
    run(8'h00, 0);

    for (int i = 0; i < 16; i++) begin
      rc = 8'($urandom);
      if ($urandom_range(0, 3) != 0)
        rc = {2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)),
              2'($urandom_range(0, 2)), 2'($urandom_range(0, 2))};
      run(rc, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
